// File: rtl/ex_alu_unit.sv
// Execute-stage ALU with a registered result and valid/ready handshakes on both sides.
// Single-cycle ops produce their result at the accept edge. Shifts by a non-zero amount
// iterate one bit per cycle before the result is presented.
module ex_alu_unit #(
    parameter int unsigned NB_DATA  = 32,
    parameter int unsigned NB_SHAMT = 5
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [4:0]         i_alu_op,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_zero
);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SLL  = 5'd2;
    localparam logic [4:0] OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;
    localparam logic [4:0] OP_AND  = 5'd9;

    localparam logic [NB_SHAMT-1:0] CNT_ONE  = NB_SHAMT'(1);
    localparam logic [NB_SHAMT-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e              r_state;
    logic [NB_DATA-1:0]  r_result;
    logic [NB_DATA-1:0]  r_shift;
    logic [NB_SHAMT-1:0] r_cnt;
    logic [4:0]          r_op;

    logic                w_accept;
    logic                w_is_shift;
    logic [NB_SHAMT-1:0] w_shamt;
    logic [NB_DATA-1:0]  w_comb_result;
    logic [NB_DATA-1:0]  w_shift_next;

    assign w_shamt    = i_data_b[NB_SHAMT-1:0];
    assign w_is_shift = (i_alu_op == OP_SLL) || (i_alu_op == OP_SRL) || (i_alu_op == OP_SRA);

    // Handshake: a new op may enter when idle or when the held result is consumed this cycle.
    assign o_ready  = (r_state == StIdle) || ((r_state == StDone) && i_ready);
    assign w_accept = i_valid && o_ready;
    assign o_valid  = (r_state == StDone);
    assign o_result = r_result;
    assign o_zero   = (r_result == '0);

    // Single-cycle result; shifts only reach this path with a zero amount, so they pass A through.
    always_comb begin
        w_comb_result = i_data_a + i_data_b;
        case (i_alu_op)
            OP_ADD:  w_comb_result = i_data_a + i_data_b;
            OP_SUB:  w_comb_result = i_data_a - i_data_b;
            OP_SLL:  w_comb_result = i_data_a;
            OP_SRL:  w_comb_result = i_data_a;
            OP_SRA:  w_comb_result = i_data_a;
            OP_SLT:  w_comb_result = {{(NB_DATA-1){1'b0}},
                                      ($signed(i_data_a) < $signed(i_data_b))};
            OP_SLTU: w_comb_result = {{(NB_DATA-1){1'b0}}, (i_data_a < i_data_b)};
            OP_XOR:  w_comb_result = i_data_a ^ i_data_b;
            OP_OR:   w_comb_result = i_data_a | i_data_b;
            OP_AND:  w_comb_result = i_data_a & i_data_b;
            default: w_comb_result = i_data_a + i_data_b;
        endcase
    end

    // One-bit step of the in-flight shift, selected by the op captured at accept.
    always_comb begin
        w_shift_next = {r_shift[NB_DATA-2:0], 1'b0};
        if (r_op == OP_SRL) begin
            w_shift_next = {1'b0, r_shift[NB_DATA-1:1]};
        end else if (r_op == OP_SRA) begin
            w_shift_next = {r_shift[NB_DATA-1], r_shift[NB_DATA-1:1]};
        end
    end

    // FSM plus datapath registers; reset discards any shift in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_result <= '0;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_op     <= OP_ADD;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    if (w_accept) begin
                        if (w_is_shift && (w_shamt != CNT_ZERO)) begin
                            r_shift <= i_data_a;
                            r_cnt   <= w_shamt;
                            r_op    <= i_alu_op;
                            r_state <= StShift;
                        end else begin
                            r_result <= w_comb_result;
                            r_state  <= StDone;
                        end
                    end else if ((r_state == StDone) && i_ready) begin
                        r_state <= StIdle;
                    end
                end
                StShift: begin
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_result <= w_shift_next;
                        r_state  <= StDone;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule
